// File: rtl/oup_ulpi_reg_engine.sv
// rtl/oup_ulpi_reg_engine.sv - queued ULPI PHY register-access engine with retry, RX CMD capture and PHY reset
module oup_ulpi_reg_engine #(
  parameter int CMD_DEPTH   = 4,
  parameter int EXT_ADDR_EN = 1,
  parameter int MAX_RETRY   = 3,
  parameter int RST_CYCLES  = 8
) (
  input  logic                           ulpi_clk_i,
  input  logic                           rst_n_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_write_i,
  input  logic [7:0]                     cmd_addr_i,
  input  logic [7:0]                     cmd_data_i,
  input  logic                           flush_i,
  output logic [$clog2(CMD_DEPTH+1)-1:0] fifo_level_o,
  output logic                           busy_o,
  output logic                           rsp_valid_o,
  output logic                           rsp_write_o,
  output logic [7:0]                     rsp_addr_o,
  output logic [7:0]                     rsp_data_o,
  output logic [1:0]                     rsp_status_o,
  output logic                           rxcmd_valid_o,
  output logic [7:0]                     rxcmd_o,
  input  logic                           phy_rst_req_i,
  output logic                           ulpi_rst_o,
  input  logic [7:0]                     ulpi_data_i,
  output logic [7:0]                     ulpi_data_o,
  output logic                           ulpi_data_oe_o,
  input  logic                           ulpi_dir_i,
  input  logic                           ulpi_nxt_i,
  output logic                           ulpi_stp_o
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int LW = $clog2(CMD_DEPTH + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_ABORTED  = 2'b01;
  localparam logic [1:0] RSP_ILLEGAL  = 2'b10;
  localparam logic [1:0] RSP_PROTOCOL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_TXCMD, S_EXTADDR, S_WDATA, S_STP, S_RDTURN, S_RDDATA, S_WAITLOW, S_RST
  } state_t;

  // 0x2F is the escape code in the immediate address space, so it can only go out extended
  function automatic logic is_ext(input logic [7:0] a);
    return (a >= 8'h40) || (a == 8'h2F);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [16:0]       r_mem [CMD_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_count;
  logic [LW-1:0]     w_count_nxt;
  logic              r_ready;
  logic              r_dir_q;
  logic              r_cmd_write;
  logic [7:0]        r_cmd_addr;
  logic [7:0]        r_cmd_data;
  logic [7:0]        r_rdata;
  logic [RW-1:0]     r_retry;
  logic              r_reissue;
  logic              r_abort;
  logic              r_rst_pend;
  logic              r_rst_pulse;
  logic [CW-1:0]     r_rst_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [7:0]        r_rsp_addr;
  logic [7:0]        r_rsp_data;
  logic [1:0]        r_rsp_status;
  logic              r_rxcmd_valid;
  logic [7:0]        r_rxcmd;

  logic              w_push;
  logic              w_pop;
  logic              w_bus_free;
  logic              w_head_write;
  logic [7:0]        w_head_addr;
  logic [7:0]        w_head_data;
  logic              w_head_illegal;
  logic              w_cmd_ext;
  logic [7:0]        w_txcmd;
  logic              w_start_tx;
  logic              w_start_rst;
  logic              w_rsp_fire;
  logic              w_rsp_head;
  logic [1:0]        w_rsp_status;
  logic              w_set_abort;
  logic              w_clr_abort;
  logic              w_retry;
  logic              w_latch;
  logic              w_drive;
  logic              w_stp;
  logic [7:0]        w_dout;
  logic              w_rx_capture;

  assign w_push         = cmd_valid_i & r_ready & ~flush_i;
  assign w_bus_free     = ~ulpi_dir_i & ~r_dir_q;
  assign {w_head_write, w_head_addr, w_head_data} = r_mem[r_rd_ptr];
  assign w_head_illegal = (EXT_ADDR_EN == 0) && is_ext(w_head_addr);
  assign w_cmd_ext      = (EXT_ADDR_EN != 0) && is_ext(r_cmd_addr);
  assign w_txcmd        = w_cmd_ext ? (r_cmd_write ? 8'hAF : 8'hEF)
                                    : {1'b1, ~r_cmd_write, r_cmd_addr[5:0]};
  assign w_rx_capture   = ulpi_dir_i & r_dir_q & ~ulpi_nxt_i & (r_state != S_RDDATA);

  always_comb begin
    w_count_nxt = r_count;
    if (flush_i) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + LW'(1);
        2'b01:   w_count_nxt = r_count - LW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge ulpi_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_write_i, cmd_addr_i, cmd_data_i};
  end

  always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // ready reflects the post-update level, so a full FIFO stays unready even while popping
      r_ready <= (w_count_nxt != LW'(CMD_DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (flush_i)    r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_start_tx   = 1'b0;
    w_start_rst  = 1'b0;
    w_rsp_fire   = 1'b0;
    w_rsp_head   = 1'b0;
    w_rsp_status = RSP_OK;
    w_set_abort  = 1'b0;
    w_clr_abort  = 1'b0;
    w_retry      = 1'b0;
    w_latch      = 1'b0;
    w_drive      = 1'b0;
    w_stp        = 1'b0;
    w_dout       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (r_rst_pend) begin
          w_start_rst = 1'b1;
          w_state_nxt = S_RST;
        end else if (w_bus_free) begin
          if (r_reissue) begin
            w_start_tx  = 1'b1;
            w_state_nxt = S_TXCMD;
          end else if (r_count != '0) begin
            w_pop = 1'b1;
            if (w_head_illegal) begin
              w_rsp_fire   = 1'b1;
              w_rsp_head   = 1'b1;
              w_rsp_status = RSP_ILLEGAL;
            end else begin
              w_state_nxt = S_TXCMD;
            end
          end
        end
      end
      S_TXCMD: begin
        w_drive = 1'b1;
        w_dout  = w_txcmd;
        if (ulpi_dir_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_WAITLOW;
        end else if (ulpi_nxt_i) begin
          w_state_nxt = w_cmd_ext ? S_EXTADDR : (r_cmd_write ? S_WDATA : S_RDTURN);
        end
      end
      S_EXTADDR: begin
        w_drive = 1'b1;
        w_dout  = r_cmd_addr;
        if (ulpi_dir_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_WAITLOW;
        end else if (ulpi_nxt_i) begin
          w_state_nxt = r_cmd_write ? S_WDATA : S_RDTURN;
        end
      end
      S_WDATA: begin
        w_drive = 1'b1;
        w_dout  = r_cmd_data;
        if (ulpi_dir_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_WAITLOW;
        end else if (ulpi_nxt_i) begin
          w_state_nxt = S_STP;
        end
      end
      S_STP: begin
        w_drive     = 1'b1;
        w_stp       = 1'b1;
        w_rsp_fire  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RDTURN: begin
        if (ulpi_dir_i) begin
          w_state_nxt = S_RDDATA;
        end else begin
          w_rsp_fire   = 1'b1;
          w_rsp_status = RSP_PROTOCOL;
          w_state_nxt  = S_IDLE;
        end
      end
      S_RDDATA: begin
        if (ulpi_nxt_i) w_set_abort = 1'b1;
        else            w_latch     = 1'b1;
        w_state_nxt = S_WAITLOW;
      end
      S_WAITLOW: begin
        if (!ulpi_dir_i) begin
          w_clr_abort = 1'b1;
          w_state_nxt = S_IDLE;
          if (!r_abort) begin
            w_rsp_fire = 1'b1;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            w_retry = 1'b1;
          end else begin
            w_rsp_fire   = 1'b1;
            w_rsp_status = RSP_ABORTED;
          end
        end
      end
      S_RST: begin
        if (r_rst_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_dir_q       <= 1'b0;
      r_cmd_write   <= 1'b0;
      r_cmd_addr    <= 8'h00;
      r_cmd_data    <= 8'h00;
      r_rdata       <= 8'h00;
      r_retry       <= '0;
      r_reissue     <= 1'b0;
      r_abort       <= 1'b0;
      r_rst_pend    <= 1'b0;
      r_rst_pulse   <= 1'b0;
      r_rst_cnt     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_addr    <= 8'h00;
      r_rsp_data    <= 8'h00;
      r_rsp_status  <= 2'b00;
      r_rxcmd_valid <= 1'b0;
      r_rxcmd       <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_dir_q     <= ulpi_dir_i;
      r_rst_pulse <= (w_state_nxt == S_RST);
      if (w_pop) begin
        r_cmd_write <= w_head_write;
        r_cmd_addr  <= w_head_addr;
        r_cmd_data  <= w_head_data;
        r_retry     <= '0;
      end else if (w_retry) begin
        r_retry <= r_retry + RW'(1);
      end
      if (w_retry)         r_reissue <= 1'b1;
      else if (w_start_tx) r_reissue <= 1'b0;
      if (w_set_abort)      r_abort <= 1'b1;
      else if (w_clr_abort) r_abort <= 1'b0;
      if (w_latch) r_rdata <= ulpi_data_i;
      if (w_start_rst)                             r_rst_pend <= 1'b0;
      else if (phy_rst_req_i && r_state != S_RST)  r_rst_pend <= 1'b1;
      if (w_start_rst)            r_rst_cnt <= CW'(RST_CYCLES - 1);
      else if (r_state == S_RST)  r_rst_cnt <= r_rst_cnt - CW'(1);
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_status <= w_rsp_status;
        if (w_rsp_head) begin
          r_rsp_write <= w_head_write;
          r_rsp_addr  <= w_head_addr;
          r_rsp_data  <= w_head_data;
        end else begin
          r_rsp_write <= r_cmd_write;
          r_rsp_addr  <= r_cmd_addr;
          r_rsp_data  <= r_cmd_write ? r_cmd_data : r_rdata;
        end
      end
      r_rxcmd_valid <= w_rx_capture;
      if (w_rx_capture) r_rxcmd <= ulpi_data_i;
    end
  end

  assign cmd_ready_o    = r_ready;
  assign fifo_level_o   = r_count;
  assign busy_o         = (r_state != S_IDLE) | r_reissue;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_write_o    = r_rsp_write;
  assign rsp_addr_o     = r_rsp_addr;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_status_o   = r_rsp_status;
  assign rxcmd_valid_o  = r_rxcmd_valid;
  assign rxcmd_o        = r_rxcmd;
  assign ulpi_rst_o     = ~rst_n_i | r_rst_pulse;
  assign ulpi_data_o    = w_dout;
  assign ulpi_data_oe_o = w_drive & ~ulpi_dir_i;
  assign ulpi_stp_o     = w_stp;

endmodule

// File: tb/tb_oup_ulpi_reg_engine.sv
// tb/tb_oup_ulpi_reg_engine.sv - self-checking bench for oup_ulpi_reg_engine
module tb_oup_ulpi_reg_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_cmd_valid, a_cmd_write, a_flush, a_phy_rst_req, a_dir, a_nxt;
  logic [7:0] a_cmd_addr, a_cmd_data, a_data_in;
  logic       a_cmd_ready, a_busy, a_rsp_valid, a_rsp_write, a_rxv, a_urst, a_oe, a_stp;
  logic [2:0] a_level;
  logic [7:0] a_rsp_addr, a_rsp_data, a_rxcmd, a_dout;
  logic [1:0] a_rsp_status;

  logic       b_cmd_valid, b_cmd_write, b_flush, b_phy_rst_req, b_dir, b_nxt;
  logic [7:0] b_cmd_addr, b_cmd_data, b_data_in;
  logic       b_cmd_ready, b_busy, b_rsp_valid, b_rsp_write, b_rxv, b_urst, b_oe, b_stp;
  logic [2:0] b_level;
  logic [7:0] b_rsp_addr, b_rsp_data, b_rxcmd, b_dout;
  logic [1:0] b_rsp_status;

  oup_ulpi_reg_engine #(.CMD_DEPTH(4), .EXT_ADDR_EN(1), .MAX_RETRY(3), .RST_CYCLES(8)) u_dut_a (
    .ulpi_clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(a_cmd_valid), .cmd_ready_o(a_cmd_ready),
    .cmd_write_i(a_cmd_write), .cmd_addr_i(a_cmd_addr), .cmd_data_i(a_cmd_data), .flush_i(a_flush),
    .fifo_level_o(a_level), .busy_o(a_busy), .rsp_valid_o(a_rsp_valid), .rsp_write_o(a_rsp_write),
    .rsp_addr_o(a_rsp_addr), .rsp_data_o(a_rsp_data), .rsp_status_o(a_rsp_status),
    .rxcmd_valid_o(a_rxv), .rxcmd_o(a_rxcmd), .phy_rst_req_i(a_phy_rst_req), .ulpi_rst_o(a_urst),
    .ulpi_data_i(a_data_in), .ulpi_data_o(a_dout), .ulpi_data_oe_o(a_oe), .ulpi_dir_i(a_dir),
    .ulpi_nxt_i(a_nxt), .ulpi_stp_o(a_stp));

  oup_ulpi_reg_engine #(.CMD_DEPTH(4), .EXT_ADDR_EN(0), .MAX_RETRY(1), .RST_CYCLES(8)) u_dut_b (
    .ulpi_clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
    .cmd_write_i(b_cmd_write), .cmd_addr_i(b_cmd_addr), .cmd_data_i(b_cmd_data), .flush_i(b_flush),
    .fifo_level_o(b_level), .busy_o(b_busy), .rsp_valid_o(b_rsp_valid), .rsp_write_o(b_rsp_write),
    .rsp_addr_o(b_rsp_addr), .rsp_data_o(b_rsp_data), .rsp_status_o(b_rsp_status),
    .rxcmd_valid_o(b_rxv), .rxcmd_o(b_rxcmd), .phy_rst_req_i(b_phy_rst_req), .ulpi_rst_o(b_urst),
    .ulpi_data_i(b_data_in), .ulpi_data_o(b_dout), .ulpi_data_oe_o(b_oe), .ulpi_dir_i(b_dir),
    .ulpi_nxt_i(b_nxt), .ulpi_stp_o(b_stp));

  typedef struct packed {
    logic       w;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] st;
  } rsp_t;

  typedef struct packed {
    logic       w;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] phy;
    logic [1:0] st;
    logic [7:0] exp_data;
  } vec_t;

  rsp_t sb_q[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  function automatic logic is_ext(input logic [7:0] a);
    return (a >= 8'h40) || (a == 8'h2F);
  endfunction

  always @(negedge clk) begin : mon
    rsp_t e;
    if (rst_n && a_rsp_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got addr=0x%0h status=%0d want none", a_rsp_addr, a_rsp_status);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_write", 32'(a_rsp_write), 32'(e.w));
        chk("rsp_addr", 32'(a_rsp_addr), 32'(e.addr));
        chk("rsp_data", 32'(a_rsp_data), 32'(e.data));
        chk("rsp_status", 32'(a_rsp_status), 32'(e.st));
      end
    end
  end

  task automatic push_a(input logic w, input logic [7:0] addr, input logic [7:0] data);
    a_cmd_valid = 1'b1;
    a_cmd_write = w;
    a_cmd_addr  = addr;
    a_cmd_data  = data;
    @(negedge clk);
    a_cmd_valid = 1'b0;
  endtask

  task automatic wait_sb_empty();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      note_timeout("rsp_wait");
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_oe_a(input string name);
    int guard = 0;
    while (!a_oe && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!a_oe) note_timeout(name);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] exp_b[3];
    int   nb;
    rsp_t e;
    if (is_ext(v.addr)) begin
      exp_b[0] = v.w ? 8'hAF : 8'hEF;
      exp_b[1] = v.addr;
      nb = 2;
    end else begin
      exp_b[0] = (v.w ? 8'h80 : 8'hC0) | {2'b00, v.addr[5:0]};
      nb = 1;
    end
    if (v.w) begin
      exp_b[nb] = v.data;
      nb++;
    end
    e = '{v.w, v.addr, v.exp_data, v.st};
    sb_q.push_back(e);
    push_a(v.w, v.addr, v.data);
    wait_oe_a("tx_start");
    for (int i = 0; i < nb; i++) begin
      chk("tx_oe", 32'(a_oe), 32'd1);
      chk("tx_byte", 32'(a_dout), 32'(exp_b[i]));
      @(negedge clk);
    end
    if (v.w) begin
      chk("stp", 32'(a_stp), 32'd1);
      chk("stp_data", 32'(a_dout), 32'h00);
    end else begin
      chk("rdturn_oe", 32'(a_oe), 32'd0);
      a_dir = 1'b1;
      a_nxt = 1'b0;
      @(negedge clk);
      a_data_in = v.phy;
      @(negedge clk);
      a_dir = 1'b0;
      a_nxt = 1'b1;
      a_data_in = 8'h00;
    end
    wait_sb_empty();
  endtask

  initial begin
    rsp_t e;
    int   lat, acc, hi, attempts, got, oe_seen, guard;
    vecs[0] = '{1'b1, 8'h0A, 8'h45, 8'h00, 2'b00, 8'h45};
    vecs[1] = '{1'b0, 8'h81, 8'h00, 8'h5C, 2'b00, 8'h5C};
    vecs[2] = '{1'b1, 8'h2F, 8'h11, 8'h00, 2'b00, 8'h11};
    vecs[3] = '{1'b0, 8'h16, 8'h00, 8'hA5, 2'b00, 8'hA5};
    vecs[4] = '{1'b1, 8'hFF, 8'h00, 8'h00, 2'b00, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'hFF, 2'b00, 8'hFF};

    rst_n = 1'b0;
    {a_cmd_valid, a_cmd_write, a_flush, a_phy_rst_req, a_dir} = '0;
    {b_cmd_valid, b_cmd_write, b_flush, b_phy_rst_req, b_dir} = '0;
    a_nxt = 1'b1; b_nxt = 1'b1;
    a_cmd_addr = 8'h00; a_cmd_data = 8'h00; a_data_in = 8'h00;
    b_cmd_addr = 8'h00; b_cmd_data = 8'h00; b_data_in = 8'h00;
    #1;
    chk("reset_ulpi_rst", 32'(a_urst), 32'd1);
    chk("reset_ready", 32'(a_cmd_ready), 32'd0);
    chk("reset_level", 32'(a_level), 32'd0);
    chk("reset_oe", 32'(a_oe), 32'd0);
    chk("reset_rxcmd", 32'(a_rxcmd), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 32'(a_cmd_ready), 32'd1);
    chk("ulpi_rst_released", 32'(a_urst), 32'd0);

    e = '{1'b1, 8'h0A, 8'h45, 2'b00};
    sb_q.push_back(e);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 8'h0A; a_cmd_data = 8'h45;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      a_cmd_valid = 1'b0;
      if (k == 2) begin
        chk("lat_txcmd_oe", 32'(a_oe), 32'd1);
        chk("lat_txcmd", 32'(a_dout), 32'h8A);
      end
      if (k == 3) chk("lat_wdata", 32'(a_dout), 32'h45);
      if (k == 4) chk("lat_stp", 32'(a_stp), 32'd1);
      if (a_rsp_valid && lat == 0) lat = k;
    end
    chk("write_rsp_latency", 32'(lat), 32'd5);
    wait_sb_empty();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    e = '{1'b1, 8'h04, 8'h33, 2'b00};
    sb_q.push_back(e);
    push_a(1'b1, 8'h04, 8'h33);
    wait_oe_a("abort_tx_start");
    chk("abort_txcmd", 32'(a_dout), 32'h84);
    a_dir = 1'b1;
    #1;
    chk("abort_oe_release", 32'(a_oe), 32'd0);
    @(negedge clk);
    a_data_in = 8'h4D;
    a_nxt = 1'b0;
    @(negedge clk);
    chk("rxcmd_valid", 32'(a_rxv), 32'd1);
    chk("rxcmd_byte", 32'(a_rxcmd), 32'h4D);
    a_dir = 1'b0;
    a_nxt = 1'b1;
    a_data_in = 8'h00;
    wait_oe_a("reissue_start");
    chk("reissue_txcmd", 32'(a_dout), 32'h84);
    @(negedge clk);
    chk("reissue_wdata", 32'(a_dout), 32'h33);
    @(negedge clk);
    chk("reissue_stp", 32'(a_stp), 32'd1);
    wait_sb_empty();

    a_dir = 1'b1;
    @(negedge clk);
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 8'(k + 1); a_cmd_data = 8'h10;
      if (a_cmd_ready) acc++;
      @(negedge clk);
    end
    a_cmd_valid = 1'b0;
    chk("fifo_accepted", 32'(acc), 32'd4);
    chk("fifo_level_full", 32'(a_level), 32'd4);
    chk("fifo_ready_full", 32'(a_cmd_ready), 32'd0);
    a_flush = 1'b1; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_flush = 1'b0; a_cmd_valid = 1'b0;
    chk("flush_level", 32'(a_level), 32'd0);
    @(negedge clk);
    chk("flush_ready", 32'(a_cmd_ready), 32'd1);
    a_flush = 1'b1; a_cmd_valid = 1'b1;
    @(negedge clk);
    a_flush = 1'b0; a_cmd_valid = 1'b0;
    chk("flush_wins_push", 32'(a_level), 32'd0);
    a_dir = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_idle_busy", 32'(a_busy), 32'd0);

    push_a(1'b1, 8'h07, 8'h99);
    push_a(1'b1, 8'h08, 8'h11);
    guard = 0;
    while (!(a_oe && a_dout == 8'h99) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!(a_oe && a_dout == 8'h99)) note_timeout("wdata_reach");
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", 32'(a_oe), 32'd0);
    chk("midrst_ulpi_rst", 32'(a_urst), 32'd1);
    chk("midrst_level", 32'(a_level), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_after_level", 32'(a_level), 32'd0);
    chk("midrst_after_busy", 32'(a_busy), 32'd0);

    a_phy_rst_req = 1'b1;
    @(negedge clk);
    a_phy_rst_req = 1'b0;
    hi = 0;
    for (int k = 0; k < 24; k++) begin
      a_phy_rst_req = (k == 5);
      @(negedge clk);
      if (a_urst) hi++;
    end
    a_phy_rst_req = 1'b0;
    chk("phy_rst_len", 32'(hi), 32'd8);

    b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 8'h05; b_cmd_data = 8'h77;
    attempts = 0; got = 0; guard = 0;
    while (!got && guard < 60) begin
      @(negedge clk);
      b_cmd_valid = 1'b0;
      guard++;
      if (b_rsp_valid) begin
        got = 1;
        chk("retry_status", 32'(b_rsp_status), 32'd1);
      end else if (b_oe) begin
        attempts++;
        b_dir = 1'b1;
        @(negedge clk);
        b_dir = 1'b0;
      end
    end
    if (!got) note_timeout("retry_rsp");
    chk("retry_attempts", 32'(attempts), 32'd2);
    repeat (3) @(negedge clk);

    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 8'h2F;
    lat = 0; oe_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b_cmd_valid = 1'b0;
      if (b_oe) oe_seen = 1;
      if (b_rsp_valid) begin
        lat = k;
        chk("illegal_status", 32'(b_rsp_status), 32'd2);
        chk("illegal_addr", 32'(b_rsp_addr), 32'h2F);
      end
    end
    chk("illegal_latency", 32'(lat), 32'd2);
    chk("illegal_no_oe", 32'(oe_seen), 32'd0);

    wait_sb_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
